// File: rtl/jtcop_vsig.sv
// Video signature: blanks and registers the mixer colour, measures frame geometry and CRC-16s the active pixels.
// Colour/blank outputs lag 1 pxl_cen; status byte lags st_addr by 1 clk; no backpressure (free-running video).
module jtcop_vsig #(
  parameter logic [15:0] CRC_POLY = 16'h1021,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       LHBL_dly,
  input  logic       LVBL_dly,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic [7:0] red_o,
  output logic [7:0] green_o,
  output logic [7:0] blue_o,
  output logic       LHBL_o,
  output logic       LVBL_o,
  input  logic [2:0] st_addr,
  output logic [7:0] st_dout
);

  // 24 serial shifts of the generator, MSB first, unrolled into one clock
  function automatic logic [15:0] crc24(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--)
      r = {r[14:0], 1'b0} ^ (((r[15] ^ d[i]) == 1'b1) ? CRC_POLY : 16'd0);
    return r;
  endfunction

  logic        hb_l, vb_l;
  logic [8:0]  line_cnt, cur_w, cur_h, act_w, act_h;
  logic [15:0] crc, crc_q;
  logic [7:0]  frame_cnt;

  logic        act, hb_fall, vb_rise, vb_fall, line_close;
  logic [8:0]  cur_h_nxt;
  logic [23:0] rgb;

  assign rgb        = {red, green, blue};
  assign act        = pxl_cen & LHBL_dly & LVBL_dly;
  assign hb_fall    = pxl_cen & hb_l & ~LHBL_dly;
  assign vb_rise    = pxl_cen & ~vb_l & LVBL_dly;
  assign vb_fall    = pxl_cen & vb_l & ~LVBL_dly;
  assign line_close = hb_fall & (line_cnt != 9'd0);
  assign cur_h_nxt  = (cur_h == 9'h1FF) ? cur_h : cur_h + 9'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red_o     <= 8'd0;
      green_o   <= 8'd0;
      blue_o    <= 8'd0;
      LHBL_o    <= 1'b0;
      LVBL_o    <= 1'b0;
      hb_l      <= 1'b0;
      vb_l      <= 1'b0;
      line_cnt  <= 9'd0;
      cur_w     <= 9'd0;
      cur_h     <= 9'd0;
      act_w     <= 9'd0;
      act_h     <= 9'd0;
      crc       <= CRC_INIT;
      crc_q     <= 16'd0;
      frame_cnt <= 8'd0;
    end else begin
      if (pxl_cen) begin
        hb_l    <= LHBL_dly;
        vb_l    <= LVBL_dly;
        LHBL_o  <= LHBL_dly;
        LVBL_o  <= LVBL_dly;
        red_o   <= (LHBL_dly & LVBL_dly) ? red   : 8'd0;
        green_o <= (LHBL_dly & LVBL_dly) ? green : 8'd0;
        blue_o  <= (LHBL_dly & LVBL_dly) ? blue  : 8'd0;
      end
      // A pixel landing on the frame-start edge is the first pixel of the new frame
      if (vb_rise) begin
        crc      <= act ? crc24(CRC_INIT, rgb) : CRC_INIT;
        line_cnt <= act ? 9'd1 : 9'd0;
        cur_h    <= 9'd0;
      end else begin
        if (act)
          crc <= crc24(crc, rgb);
        if (line_close) begin
          cur_w <= line_cnt;
          cur_h <= cur_h_nxt;
        end
        if (hb_fall)
          line_cnt <= 9'd0;
        else if (act && line_cnt != 9'h1FF)
          line_cnt <= line_cnt + 9'd1;
      end
      // Line close on the same pxl_cen is folded into the frame latch
      if (vb_fall) begin
        crc_q     <= crc;
        act_w     <= line_close ? line_cnt  : cur_w;
        act_h     <= line_close ? cur_h_nxt : cur_h;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_dout <= 8'd0;
    end else begin
      case (st_addr)
        3'd0:    st_dout <= crc_q[7:0];
        3'd1:    st_dout <= crc_q[15:8];
        3'd2:    st_dout <= act_w[7:0];
        3'd3:    st_dout <= {7'd0, act_w[8]};
        3'd4:    st_dout <= act_h[7:0];
        3'd5:    st_dout <= {7'd0, act_h[8]};
        3'd6:    st_dout <= frame_cnt;
        default: st_dout <= 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_jtcop_vsig.sv
// Bench for jtcop_vsig: directed frames with random colours and random pxl_cen gaps,
// checked against a frame-level geometry/CRC model.
module tb_jtcop_vsig;
  logic       clk = 1'b0;
  logic       rst, pxl_cen, LHBL_dly, LVBL_dly;
  logic [7:0] red, green, blue, red_o, green_o, blue_o;
  logic       LHBL_o, LVBL_o;
  logic [2:0] st_addr;
  logic [7:0] st_dout;

  int n_tests = 0;
  int n_fail  = 0;
  bit gap     = 1'b0;

  logic [15:0] m_crc, e_crc, c_a, c_b, c_c;
  logic [8:0]  e_w, e_h, last_w;
  logic [7:0]  e_fc, d8;
  logic [23:0] exp_rgb;
  logic        exp_lh, exp_lv;
  int          seed;

  jtcop_vsig dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly),
    .red(red), .green(green), .blue(blue),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .LHBL_o(LHBL_o), .LVBL_o(LVBL_o),
    .st_addr(st_addr), .st_dout(st_dout)
  );

  always #5 clk = ~clk;

  // Byte-at-a-time CRC-16/CCITT, MSB first
  function automatic logic [15:0] fold(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int b = 2; b >= 0; b--) begin
      r = r ^ {d[b*8 +: 8], 8'h00};
      for (int k = 0; k < 8; k++)
        r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  function automatic logic [23:0] pcol(input int s, input int l, input int p);
    if (s == 0) return 24'd0;
    return 24'((s * 32'h9E3779B1) ^ (l * 32'h85EBCA6B) ^ (p * 32'hC2B2AE35) ^ (l << 12) ^ p);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_rgb"}, 32'({red_o, green_o, blue_o}), 32'(exp_rgb));
    chk({tag, "_hbl"}, 32'(LHBL_o), 32'(exp_lh));
    chk({tag, "_vbl"}, 32'(LVBL_o), 32'(exp_lv));
  endtask

  // One pixel; in gap mode an idle cycle with scrambled inputs may precede it
  task automatic step(input logic lh, input logic lv, input logic [23:0] col);
    if (gap && $urandom_range(0, 2) == 0) begin
      pxl_cen  = 1'b0;
      LHBL_dly = ~lh;
      LVBL_dly = 1'($urandom_range(0, 1));
      {red, green, blue} = 24'($urandom);
      @(posedge clk); #1;
      chk_out("hold");
    end
    pxl_cen  = 1'b1;
    LHBL_dly = lh;
    LVBL_dly = lv;
    {red, green, blue} = col;
    @(posedge clk); #1;
    exp_rgb = (lh && lv) ? col : 24'd0;
    exp_lh  = lh;
    exp_lv  = lv;
    if (lh && lv) m_crc = fold(m_crc, col);
    chk_out("pix");
    pxl_cen = 1'b0;
  endtask

  task automatic frame(input int w, input int h, input int s, input int flip, input bit coinc);
    logic [23:0] c;
    step(1'b0, 1'b0, 24'd0);
    step(1'b0, 1'b0, 24'd0);
    m_crc = 16'hFFFF;
    step(1'b0, 1'b1, 24'd0);
    for (int l = 0; l < h; l++) begin
      for (int p = 0; p < w; p++) begin
        c = pcol(s, l, p);
        if (l == 0 && p == flip) c = c ^ 24'h000100;
        step(1'b1, 1'b1, c);
      end
      if (coinc && l == h - 1) step(1'b0, 1'b0, 24'd0);
      else begin
        step(1'b0, 1'b1, 24'd0);
        step(1'b0, 1'b1, 24'd0);
      end
    end
    if (!(coinc && h > 0)) step(1'b0, 1'b0, 24'd0);
    step(1'b0, 1'b0, 24'd0);
    e_fc  = e_fc + 8'd1;
    e_crc = m_crc;
    if (w > 0 && h > 0) last_w = (w > 511) ? 9'd511 : 9'(w);
    e_w = last_w;
    e_h = (w > 0) ? 9'(h) : 9'd0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    st_addr = a;
    @(posedge clk); #1;
    d = st_dout;
  endtask

  task automatic check_st(input string tag, output logic [15:0] dcrc);
    logic [7:0] d [8];
    for (int a = 0; a < 8; a++) rd(3'(a), d[a]);
    dcrc = {d[1], d[0]};
    chk({tag, "_crc"}, 32'(dcrc), 32'(e_crc));
    chk({tag, "_w"},   32'({d[3], d[2]}), 32'(e_w));
    chk({tag, "_h"},   32'({d[5], d[4]}), 32'(e_h));
    chk({tag, "_fc"},  32'(d[6]), 32'(e_fc));
    chk({tag, "_st7"}, 32'(d[7]), 32'h0000_00FF);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pxl_cen = 1'b0;
    LHBL_dly = 1'b0;
    LVBL_dly = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_crc = 16'hFFFF;
    e_crc = 16'd0;
    e_w = 9'd0;
    e_h = 9'd0;
    last_w = 9'd0;
    e_fc = 8'd0;
    exp_rgb = 24'd0;
    exp_lh = 1'b0;
    exp_lv = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; LHBL_dly = 1'b0; LVBL_dly = 1'b0;
    red = 8'd0; green = 8'd0; blue = 8'd0; st_addr = 3'd6;
    #1;
    chk("rst_st", 32'(st_dout), 32'd0);
    chk("rst_rgb", 32'({red_o, green_o, blue_o}), 32'd0);
    do_reset();
    check_st("after_rst", c_a);

    // Small frame with gaps so frame_cnt is nonzero before the mid-frame reset
    gap = 1'b1;
    seed = int'($urandom_range(1, 1000));
    frame(5, 3, seed, -1, 1'b0);
    check_st("small", c_a);

    // Blanking, then reset in the middle of the next frame
    step(1'b0, 1'b0, 24'hFFFFFF);
    step(1'b0, 1'b1, 24'hFFFFFF);
    step(1'b1, 1'b1, 24'hFFFFFF);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 24'($urandom));
    rst = 1'b1;
    st_addr = 3'd6;
    #1;
    chk("midrst_st", 32'(st_dout), 32'd0);
    chk("midrst_rgb", 32'({red_o, green_o, blue_o}), 32'd0);
    chk("midrst_vbl", 32'(LVBL_o), 32'd0);
    pxl_cen = 1'b1; LHBL_dly = 1'b1; LVBL_dly = 1'b1; {red, green, blue} = 24'hFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("inrst_rgb", 32'({red_o, green_o, blue_o}), 32'd0);
    do_reset();
    frame(7, 2, seed, -1, 1'b0);
    check_st("post_rst", c_a);

    // Full 256x224 colour-0 frame whose last line closes with the frame
    gap = 1'b0;
    frame(256, 224, 0, -1, 1'b1);
    check_st("geom", c_a);

    // Identical frames, then a one-bit flip
    gap = 1'b1;
    seed = int'($urandom_range(1, 1000));
    frame(16, 4, seed, -1, 1'b0);
    check_st("crc_a", c_a);
    frame(16, 4, seed, -1, 1'b0);
    check_st("crc_b", c_b);
    chk("crc_same", 32'(c_b), 32'(c_a));
    frame(16, 4, seed, int'($urandom_range(0, 15)), 1'b0);
    check_st("crc_flip", c_c);
    n_tests++;
    assert (c_c !== c_a) else begin
      n_fail++;
      $error("FAIL crc_differs: observed %0h expected not %0h", c_c, c_a);
    end

    // Frame with no active pixels
    frame(0, 3, seed, -1, 1'b0);
    check_st("empty", c_a);
    chk("empty_crc", 32'(c_a), 32'h0000_FFFF);

    // Width saturation
    frame(600, 1, seed, -1, 1'b0);
    check_st("sat", c_a);

    // frame_cnt wrap after 256 frames from reset
    gap = 1'b0;
    do_reset();
    for (int f = 0; f < 256; f++) frame(0, 0, 0, -1, 1'b0);
    rd(3'd6, d8);
    chk("wrap_fc", 32'(d8), 32'd0);
    chk("wrap_model", 32'(d8), 32'(e_fc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
